mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_resp_pkg.sv | 22 ++
 rtl/mem_array.sv | 25 ++
 rtl/mem_responder.sv | 122 ++++++++++++
 tb/tb_mem_responder.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the mem_responder slave: FSM encoding,
// read/write opcodes and the latched request record.
package mem_resp_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef struct packed {
        logic              rw;
        logic [31:0]       addr;
        logic [WORD_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/mem_array.sv
// Word storage for mem_responder: synchronous write, combinational read.
// Contents are deliberately not reset.
module mem_array
    import mem_resp_pkg::*;
#(
    parameter  int DEPTH_WORDS = 64,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mem_responder.sv
// Memory-mapped slave with a fixed response latency of WAIT_STATES+1 cycles.
// Define MEM_RESPONDER_ALIGN_CHECK_EN to flag misaligned requests via resp_err.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_STATES = 2
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    req_t        r_req;
    req_t        w_cur;
    logic        r_live;
    logic [31:0] r_rdata;
    logic        r_err;

    logic          w_accept;
    logic          w_enter_resp;
    logic          w_misalign;
    logic          w_we;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_mem_rdata;
    logic          w_unused_addr;

    // In IDLE the request is still on the inputs (WAIT_STATES = 0 goes straight
    // to RESP on the accept edge); afterwards only the latched copy counts.
    always_comb begin
        w_cur = r_req;
        if (r_state == IDLE) begin
            w_cur.rw    = req_rw;
            w_cur.addr  = req_addr;
            w_cur.wdata = req_wdata;
        end
    end

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    assign w_misalign = |w_cur.addr[1:0];
`else
    assign w_misalign = 1'b0;
`endif

    assign w_idx         = w_cur.addr[AW+1:2];
    assign w_unused_addr = ^{w_cur.addr[31:AW+2], w_cur.addr[1:0]};
    assign w_accept      = req_valid && req_ready;
    assign w_enter_resp  = (w_next == RESP) && (r_state != RESP);
    assign w_we          = w_enter_resp && (w_cur.rw == RW_WRITE) && !w_misalign;

    mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .i_clk   (CLK),
        .i_we    (w_we),
        .i_waddr (w_idx),
        .i_wdata (w_cur.wdata),
        .i_raddr (w_idx),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = (WAIT_STATES == 0) ? RESP : WAIT;
            WAIT:    if (r_cnt == 4'd1) w_next = RESP;
            RESP:    if (resp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (r_state == IDLE) && r_live;
        resp_valid = (r_state == RESP);
        resp_rdata = r_rdata;
        resp_err   = r_err;
    end

    // r_live keeps req_ready low while Reset is held so nothing is accepted
    // (or written) until the first edge after release.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_cnt   <= '0;
            r_req   <= '0;
            r_live  <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (w_accept) begin
                r_req <= w_cur;
                r_cnt <= 4'(WAIT_STATES);
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_enter_resp) begin
                r_rdata <= (w_cur.rw == RW_READ && !w_misalign) ? w_mem_rdata : '0;
                r_err   <= w_misalign;
            end else if (r_state == RESP && resp_ready) begin
                r_rdata <= '0;
                r_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: WAIT_STATES=2 instance for function and
// reset checks, WAIT_STATES=0 instance for back-to-back throughput.
module tb_mem_responder;

    localparam int WS    = 2;
    localparam int DEPTH = 64;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        CLK;
    logic        Reset;
    logic        req_valid, req_ready, req_rw, resp_valid, resp_ready, resp_err;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic        z_req_valid, z_req_ready, z_req_rw, z_resp_valid, z_resp_ready, z_resp_err;
    logic [31:0] z_req_addr, z_req_wdata, z_resp_rdata;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    exp_t        sb0[$];
    logic [31:0] mdl  [DEPTH];
    logic [31:0] mdl0 [DEPTH];
    int          n_checks = 0;
    int          n_fail   = 0;

    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
        .CLK(CLK), .Reset(Reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
        .CLK(CLK), .Reset(Reset),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_rw(z_req_rw),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata),
        .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
        .resp_rdata(z_resp_rdata), .resp_err(z_resp_err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input bit sel, input logic rw,
                                   input logic [31:0] addr, input logic [31:0] wd);
        exp_t e;
        int   idx;
        idx     = int'(addr[7:2]);
        e.rdata = '0;
        e.err   = 1'b0;
        if (ALIGN_EN && addr[1:0] != 2'b00) begin
            e.err = 1'b1;
        end else if (rw) begin
            if (sel) mdl0[idx] = wd;
            else     mdl[idx]  = wd;
        end else begin
            e.rdata = sel ? mdl0[idx] : mdl[idx];
        end
        return e;
    endfunction

    task automatic do_txn(input logic rw, input logic [31:0] addr,
                          input logic [31:0] wd, input int hold);
        exp_t        e;
        int          t;
        int          lat;
        logic [31:0] held;
        @(negedge CLK);
        t = 0;
        while (req_ready !== 1'b1 && t < 50) begin
            @(negedge CLK);
            t++;
        end
        if (req_ready !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL txn_ready_timeout addr=%h", addr);
            return;
        end
        req_valid = 1'b1; req_rw = rw; req_addr = addr; req_wdata = wd;
        sb.push_back(model(1'b0, rw, addr, wd));
        @(posedge CLK);
        @(negedge CLK);
        // scramble inputs after accept: the latched request must be used
        req_valid = 1'b0; req_rw = ~rw; req_addr = ~addr; req_wdata = ~wd;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 40) begin
            @(negedge CLK);
            lat++;
        end
        n_checks++;
        if (lat != WS + 1) begin
            n_fail++;
            $display("FAIL latency addr=%h got=%0d exp=%0d", addr, lat, WS + 1);
        end
        e = sb.pop_front();
        if (resp_valid !== 1'b1) return;
        n_checks++;
        if (resp_rdata !== e.rdata || resp_err !== e.err) begin
            n_fail++;
            $display("FAIL resp_data addr=%h rw=%0d got=%h/%0b exp=%h/%0b",
                     addr, rw, resp_rdata, resp_err, e.rdata, e.err);
        end
        held = resp_rdata;
        for (int h = 0; h < hold; h++) begin
            @(negedge CLK);
            n_checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== held || req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL resp_hold cyc=%0d got v=%b d=%h rdy=%b exp v=1 d=%h rdy=0",
                         h, resp_valid, resp_rdata, req_ready, held);
            end
        end
        resp_ready = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        resp_ready = 1'b0;
        n_checks++;
        if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_handshake got v=%b d=%h rdy=%b exp v=0 d=0 rdy=1",
                     resp_valid, resp_rdata, req_ready);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        #3 Reset = 1'b0;
        #1;
        n_checks++;
        if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got v=%b d=%h e=%b exp 0/0/0",
                     resp_valid, resp_rdata, resp_err);
        end
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        Reset = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        n_checks++;
        if (req_ready !== 1'b1 || z_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready got %b/%b exp 1/1", req_ready, z_req_ready);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++)
            do_txn(1'b1, 32'(i * 4), 32'hC0DE_0000 | 32'(i), 0);
    endtask

    task automatic test_basic();
        do_txn(1'b1, 32'h10, 32'hDEAD_BEEF, 0);
        do_txn(1'b0, 32'h10, 32'h0, 5);
        do_txn(1'b0, 32'h14, 32'h0, 1);
    endtask

    task automatic test_wrap();
        do_txn(1'b1, 32'h104, 32'h0000_1234, 0);
        do_txn(1'b0, 32'h004, 32'h0, 0);
        do_txn(1'b0, 32'hFFFF_FF04, 32'h0, 0);
    endtask

    task automatic test_align();
        do_txn(1'b1, 32'h20, 32'h3333_3333, 0);
        do_txn(1'b1, 32'h22, 32'h4444_4444, 0);
        do_txn(1'b0, 32'h20, 32'h0, 0);
        do_txn(1'b0, 32'h23, 32'h0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++)
            do_txn(1'($urandom_range(0, 1)), 32'($urandom_range(0, 1023)) << 2,
                   32'($urandom), int'($urandom_range(0, 2)));
    endtask

    task automatic test_reset_abort();
        int t;
        // abort a write while it is still waiting: it must never reach the array
        @(negedge CLK);
        req_valid = 1'b1; req_rw = 1'b1; req_addr = 32'h20; req_wdata = 32'hAAAA_5555;
        @(posedge CLK);
        @(negedge CLK);
        req_valid = 1'b0;
        n_checks++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_in_wait got rdy=%b v=%b exp 0/0", req_ready, resp_valid);
        end
        Reset = 1'b0;
        #1;
        n_checks++;
        if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_outputs got v=%b d=%h e=%b exp 0/0/0",
                     resp_valid, resp_rdata, resp_err);
        end
        @(posedge CLK);
        @(negedge CLK);
        Reset = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_ready got %b exp 1", req_ready);
        end
        do_txn(1'b0, 32'h20, 32'h0, 0);
        // reset while a read response is being held
        @(negedge CLK);
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 32'h10; req_wdata = 32'h0;
        @(posedge CLK);
        @(negedge CLK);
        req_valid = 1'b0;
        t = 0;
        while (resp_valid !== 1'b1 && t < 40) begin
            @(negedge CLK);
            t++;
        end
        n_checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== mdl[4]) begin
            n_fail++;
            $display("FAIL abort_resp_pre got v=%b d=%h exp v=1 d=%h", resp_valid, resp_rdata, mdl[4]);
        end
        Reset = 1'b0;
        #1;
        n_checks++;
        if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_resp_clear got v=%b d=%h e=%b exp 0/0/0",
                     resp_valid, resp_rdata, resp_err);
        end
        @(negedge CLK);
        Reset = 1'b1;
        do_txn(1'b0, 32'h10, 32'h0, 0);
    endtask

    task automatic test_back_to_back();
        int   n;
        exp_t e;
        logic rw;
        n = 0;
        z_resp_ready = 1'b1;
        @(negedge CLK);
        for (int c = 0; c < 16; c++) begin
            n_checks++;
            if (z_req_ready !== 1'((c % 2) == 0) || z_resp_valid !== 1'((c % 2) == 1)) begin
                n_fail++;
                $display("FAIL b2b_pattern cyc=%0d got rdy=%b v=%b exp rdy=%0d v=%0d",
                         c, z_req_ready, z_resp_valid, (c % 2) == 0, (c % 2) == 1);
            end
            if (z_resp_valid === 1'b1 && sb0.size() > 0) begin
                e = sb0.pop_front();
                n_checks++;
                if (z_resp_rdata !== e.rdata || z_resp_err !== e.err) begin
                    n_fail++;
                    $display("FAIL b2b_data cyc=%0d got %h/%b exp %h/%b",
                             c, z_resp_rdata, z_resp_err, e.rdata, e.err);
                end
            end
            if (z_req_ready === 1'b1 && n < 8) begin
                rw           = (n < 4);
                z_req_valid  = 1'b1;
                z_req_rw     = rw;
                z_req_addr   = 32'h40 + 32'((n % 4) * 4);
                z_req_wdata  = 32'h5A00_0000 + 32'(n * 17);
                sb0.push_back(model(1'b1, rw, z_req_addr, z_req_wdata));
                n++;
            end
            @(negedge CLK);
        end
        z_req_valid  = 1'b0;
        z_resp_ready = 1'b0;
        n_checks++;
        if (sb0.size() != 0 || n != 8) begin
            n_fail++;
            $display("FAIL b2b_count got issued=%0d left=%0d exp issued=8 left=0", n, sb0.size());
        end
    endtask

    initial begin
        Reset = 1'b1;
        req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        z_req_valid = 1'b0; z_req_rw = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_resp_ready = 1'b0;
        test_reset();
        test_fill();
        test_basic();
        test_wrap();
        test_align();
        test_random();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
